// File: rtl/regwb_arbiter.sv
// Register-file write-port arbiter: primary writeback vs queued secondary writes.
// Optional macro WB_BYPASS_EN: direct secondary write when the queue is idle.
module regwb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p_wr,
  input  logic [4:0]               p_wreg,
  input  logic [31:0]              p_wdata,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [4:0]               s_wreg,
  input  logic [31:0]              s_wdata,
  output logic                     regwr,
  output logic [4:0]               wreg,
  output logic [31:0]              wdata,
  output logic                     stall,
  output logic [31:0]              busy_mask,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  localparam logic [AW:0] FULLC = (AW+1)'(DEPTH);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             stall_q, err_q;
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      count_q;
  logic [DEPTH-1:0] vld_q;
  logic [4:0]       reg_q [DEPTH];
  logic [31:0]      dat_q [DEPTH];

  logic empty, full, accept, push, pop;
  logic p_nrm, blocked, byp;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULLC);
  assign s_ready = !full;
  assign accept  = s_valid & s_ready;
  assign p_nrm   = p_wr & (state_q == NORMAL);
  assign blocked = p_nrm & !empty;

`ifdef WB_BYPASS_EN
  assign byp = !rst & empty & (state_q == NORMAL)
             & !p_wr & s_valid & (s_wreg != 5'd0);
`else
  assign byp = 1'b0;
`endif

  // Writes to r0 are acknowledged but never occupy a slot.
  assign push = accept & (s_wreg != 5'd0) & !byp;
  assign pop  = !rst & !empty & ((state_q == FORCE) | !p_wr);

  always_comb begin
    regwr = 1'b0;
    wreg  = empty ? 5'd0 : reg_q[rd_q];
    wdata = empty ? 32'd0 : dat_q[rd_q];
    unique case (1'b1)
      pop: regwr = 1'b1;
      p_nrm: begin
        regwr = 1'b1;
        wreg  = p_wreg;
        wdata = p_wdata;
      end
      byp: begin
        regwr = 1'b1;
        wreg  = s_wreg;
        wdata = s_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d   = 4'd0;
    state_d = NORMAL;
    if (blocked)
      cnt_d = (cnt_q >= SMAX) ? SMAX : cnt_q + 4'd1;
    if (state_q == NORMAL && blocked && cnt_d == SMAX)
      state_d = FORCE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
      cnt_q   <= 4'd0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= (state_d == FORCE);
      err_q   <= err_q | ((state_q == FORCE) & p_wr);
      if (pop) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= AW'(rd_q + 1'b1);
      end
      if (push) begin
        vld_q[wr_q] <= 1'b1;
        wr_q        <= AW'(wr_q + 1'b1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      reg_q[wr_q] <= s_wreg;
      dat_q[wr_q] <= s_wdata;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i]) busy_mask[reg_q[i]] = 1'b1;
  end

  assign stall   = stall_q;
  assign err     = err_q;
  assign q_count = count_q;

endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed cycle-by-cycle vector bench for regwb_arbiter (DEPTH=2, STARVE_MAX=4).
module tb_regwb_arbiter;

  logic        clk = 1'b0;
  logic        rst, p_wr, s_valid, s_ready;
  logic [4:0]  p_wreg, s_wreg, wreg;
  logic [31:0] p_wdata, s_wdata, wdata, busy_mask;
  logic        regwr, stall, err;
  logic [1:0]  q_count;

  int n_chk = 0;
  int n_fail = 0;

  regwb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .p_wr(p_wr), .p_wreg(p_wreg), .p_wdata(p_wdata),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_wreg(s_wreg), .s_wdata(s_wdata),
    .regwr(regwr), .wreg(wreg), .wdata(wdata),
    .stall(stall), .busy_mask(busy_mask),
    .q_count(q_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        chk;
    bit        rst;
    bit        pw;
    bit [4:0]  pr;
    bit [31:0] pd;
    bit        sv;
    bit [4:0]  sr;
    bit [31:0] sd;
    bit        e_wr;
    bit        chkd;
    bit [4:0]  e_reg;
    bit [31:0] e_dat;
    bit        e_rdy;
    bit        e_stall;
    bit [31:0] e_busy;
    bit [1:0]  e_q;
    bit        e_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    bit c, bit r, bit pw, bit [4:0] pr, bit [31:0] pd,
    bit sv, bit [4:0] sr, bit [31:0] sd,
    bit ew, bit cd, bit [4:0] er, bit [31:0] ed,
    bit rdy, bit st, bit [31:0] bm, bit [1:0] q, bit e);
    vec_t v;
    v.chk = c; v.rst = r; v.pw = pw; v.pr = pr; v.pd = pd;
    v.sv = sv; v.sr = sr; v.sd = sd;
    v.e_wr = ew; v.chkd = cd; v.e_reg = er; v.e_dat = ed;
    v.e_rdy = rdy; v.e_stall = st; v.e_busy = bm;
    v.e_q = q; v.e_err = e;
    return v;
  endfunction

  task automatic cmp(int row, string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL row %0d %s: got 0x%0h expected 0x%0h", row, nm, act, exp);
    end
  endtask

  initial begin
    // reset held two cycles
    vq.push_back(mk(0,1, 0,0,0,       0,0,0,     0,0,0,0,        1,0,0,0,0));
    vq.push_back(mk(1,1, 0,0,0,       0,0,0,     0,0,0,0,        1,0,0,0,0));
    // primary pass-through
    vq.push_back(mk(1,0, 1,5,32'h1234,0,0,0,     1,1,5,32'h1234, 1,0,0,0,0));
    // secondary push, written next cycle
    vq.push_back(mk(1,0, 0,0,0,       1,8,32'hAA,0,0,0,0,        1,0,0,0,0));
    vq.push_back(mk(1,0, 0,0,0,       0,0,0,     1,1,8,32'hAA,   1,0,32'h100,1,0));
    vq.push_back(mk(1,0, 0,0,0,       0,0,0,     0,0,0,0,        1,0,0,0,0));
    // push to r0 is swallowed
    vq.push_back(mk(1,0, 0,0,0,       1,0,32'h55,0,0,0,0,        1,0,0,0,0));
    vq.push_back(mk(1,0, 0,0,0,       0,0,0,     0,0,0,0,        1,0,0,0,0));
    // starvation: r3 queued, primary holds the port
    vq.push_back(mk(1,0, 0,0,0,       1,3,32'h33,0,0,0,0,        1,0,0,0,0));
    vq.push_back(mk(1,0, 1,10,1,      0,0,0,     1,1,10,1,       1,0,32'h8,1,0));
    vq.push_back(mk(1,0, 1,11,2,      0,0,0,     1,1,11,2,       1,0,32'h8,1,0));
    vq.push_back(mk(1,0, 1,12,3,      0,0,0,     1,1,12,3,       1,0,32'h8,1,0));
    vq.push_back(mk(1,0, 1,13,4,      0,0,0,     1,1,13,4,       1,0,32'h8,1,0));
    vq.push_back(mk(1,0, 1,14,5,      0,0,0,     1,1,3,32'h33,   1,1,32'h8,1,0));
    vq.push_back(mk(1,0, 1,15,6,      0,0,0,     1,1,15,6,       1,0,0,0,1));
    // fill the queue while blocked, third push held
    vq.push_back(mk(1,0, 1,1,7,       1,20,32'hA0,1,1,1,7,       1,0,0,0,1));
    vq.push_back(mk(1,0, 1,1,8,       1,21,32'hA1,1,1,1,8,       1,0,32'h100000,1,1));
    vq.push_back(mk(1,0, 1,1,9,       1,22,32'hA2,1,1,1,9,       0,0,32'h300000,2,1));
    vq.push_back(mk(1,0, 1,1,10,      1,22,32'hA2,1,1,1,10,      0,0,32'h300000,2,1));
    // primary releases: FIFO drain, push+pop same cycle
    vq.push_back(mk(1,0, 0,0,0,       1,22,32'hA2,1,1,20,32'hA0, 0,0,32'h300000,2,1));
    vq.push_back(mk(1,0, 0,0,0,       1,22,32'hA2,1,1,21,32'hA1, 1,0,32'h200000,1,1));
    vq.push_back(mk(1,0, 0,0,0,       0,0,0,     1,1,22,32'hA2,  1,0,32'h400000,1,1));
    vq.push_back(mk(1,0, 0,0,0,       0,0,0,     0,0,0,0,        1,0,0,0,1));
    // reset with an entry queued
    vq.push_back(mk(1,0, 0,0,0,       1,7,32'h77,0,0,0,0,        1,0,0,0,1));
    vq.push_back(mk(1,1, 1,9,32'h99,  0,0,0,     1,1,9,32'h99,   1,0,32'h80,1,1));
    vq.push_back(mk(1,1, 0,0,0,       0,0,0,     0,0,0,0,        1,0,0,0,0));
    vq.push_back(mk(1,0, 0,0,0,       0,0,0,     0,0,0,0,        1,0,0,0,0));
    vq.push_back(mk(1,0, 0,0,0,       0,0,0,     0,0,0,0,        1,0,0,0,0));

    #1;
    for (int i = 0; i < vq.size(); i++) begin
      rst     = vq[i].rst;
      p_wr    = vq[i].pw;
      p_wreg  = vq[i].pr;
      p_wdata = vq[i].pd;
      s_valid = vq[i].sv;
      s_wreg  = vq[i].sr;
      s_wdata = vq[i].sd;
      #4;
      if (vq[i].chk) begin
        cmp(i, "regwr", 32'(regwr), 32'(vq[i].e_wr));
        if (vq[i].chkd) begin
          cmp(i, "wreg", 32'(wreg), 32'(vq[i].e_reg));
          cmp(i, "wdata", wdata, vq[i].e_dat);
        end
        cmp(i, "s_ready", 32'(s_ready), 32'(vq[i].e_rdy));
        cmp(i, "stall", 32'(stall), 32'(vq[i].e_stall));
        cmp(i, "busy_mask", busy_mask, vq[i].e_busy);
        cmp(i, "q_count", 32'(q_count), 32'(vq[i].e_q));
        cmp(i, "err", 32'(err), 32'(vq[i].e_err));
      end
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
